// File: rtl/ifid_skid_register.sv
// ----------------------------------------------------------------------------
// ifid_skid_register
//
// Pipeline register between instruction fetch and decode. It captures the
// fetched {pc, instruction} pair and hands it to decode. A two-entry skid
// buffer (main slot + skid slot) absorbs the one fetch that is already in
// flight when decode stalls, so if_ready is a flop output with no
// combinational path from id_ready.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; a held id_* entry is stable while id_ready=0.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   if_valid   in   fetch presents {if_pc, if_instr}
//   if_ready   out  block can accept (registered)
//   if_pc      in   [PC_W]    pc of fetched instruction
//   if_instr   in   [INSTR_W] fetched instruction
//   flush      in   synchronous discard of all held and incoming entries
//   id_valid   out  decode-side entry valid
//   id_ready   in   decode consumes the entry this cycle
//   id_pc      out  [PC_W]    pc of presented entry (holds across flush)
//   id_instr   out  [INSTR_W] presented instruction, NOP_INSTR when empty
//   id_illegal out  entry has a non-32-bit encoding (instr[1:0] != 2'b11)
//
// Optional feature, macro IFID_PERF_CNT_EN:
//   stall_cnt  out  [32] cycles with id_valid & !id_ready (saturating)
//   flush_cnt  out  [32] cycles with flush=1 (saturating)
// ----------------------------------------------------------------------------
module ifid_skid_register #(
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_illegal
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    // Main slot drives the decode side.
    logic               r_main_valid;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;
    logic               r_main_illegal;

    // Skid slot holds the entry accepted while main was stalled.
    logic               r_skid_valid;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               r_skid_illegal;

    logic               r_if_ready;

    logic               w_accept;
    logic               w_consume;
    logic               w_in_illegal;

    logic               w_main_valid_nxt;
    logic [PC_W-1:0]    w_main_pc_nxt;
    logic [INSTR_W-1:0] w_main_instr_nxt;
    logic               w_main_illegal_nxt;
    logic               w_skid_valid_nxt;
    logic [PC_W-1:0]    w_skid_pc_nxt;
    logic [INSTR_W-1:0] w_skid_instr_nxt;
    logic               w_skid_illegal_nxt;
    logic               w_if_ready_nxt;

    assign w_accept     = if_valid & r_if_ready;
    assign w_consume    = r_main_valid & id_ready;
    assign w_in_illegal = (if_instr[1:0] != 2'b11);

    always_comb begin
        w_main_valid_nxt   = r_main_valid;
        w_main_pc_nxt      = r_main_pc;
        w_main_instr_nxt   = r_main_instr;
        w_main_illegal_nxt = r_main_illegal;
        w_skid_valid_nxt   = r_skid_valid;
        w_skid_pc_nxt      = r_skid_pc;
        w_skid_instr_nxt   = r_skid_instr;
        w_skid_illegal_nxt = r_skid_illegal;

        if (flush) begin
            // Payload registers are left alone so id_pc keeps its last value.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                // Oldest entry sits in skid: promote it, newcomer backfills skid.
                w_main_valid_nxt   = 1'b1;
                w_main_pc_nxt      = r_skid_pc;
                w_main_instr_nxt   = r_skid_instr;
                w_main_illegal_nxt = r_skid_illegal;
                w_skid_valid_nxt   = w_accept;
                if (w_accept) begin
                    w_skid_pc_nxt      = if_pc;
                    w_skid_instr_nxt   = if_instr;
                    w_skid_illegal_nxt = w_in_illegal;
                end
            end else begin
                w_main_valid_nxt = w_accept;
                w_skid_valid_nxt = 1'b0;
                if (w_accept) begin
                    w_main_pc_nxt      = if_pc;
                    w_main_instr_nxt   = if_instr;
                    w_main_illegal_nxt = w_in_illegal;
                end
            end
        end else if (w_accept) begin
            // Main is stalled: the in-flight fetch lands in skid.
            w_skid_valid_nxt   = 1'b1;
            w_skid_pc_nxt      = if_pc;
            w_skid_instr_nxt   = if_instr;
            w_skid_illegal_nxt = w_in_illegal;
        end

        w_if_ready_nxt = !w_skid_valid_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid   <= 1'b0;
            r_main_pc      <= '0;
            r_main_instr   <= NOP_INSTR;
            r_main_illegal <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_pc      <= '0;
            r_skid_instr   <= NOP_INSTR;
            r_skid_illegal <= 1'b0;
            r_if_ready     <= 1'b1;
        end else begin
            r_main_valid   <= w_main_valid_nxt;
            r_main_pc      <= w_main_pc_nxt;
            r_main_instr   <= w_main_instr_nxt;
            r_main_illegal <= w_main_illegal_nxt;
            r_skid_valid   <= w_skid_valid_nxt;
            r_skid_pc      <= w_skid_pc_nxt;
            r_skid_instr   <= w_skid_instr_nxt;
            r_skid_illegal <= w_skid_illegal_nxt;
            r_if_ready     <= w_if_ready_nxt;
        end
    end

    assign if_ready   = r_if_ready;
    assign id_valid   = r_main_valid;
    assign id_pc      = r_main_pc;
    assign id_instr   = r_main_valid ? r_main_instr : NOP_INSTR;
    assign id_illegal = r_main_valid & r_main_illegal;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_valid && !id_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifid_skid_register.sv
// ----------------------------------------------------------------------------
// Bench for ifid_skid_register: directed vector table, hand-written reset and
// counter sequences, then random traffic against a queue-based model.
// ----------------------------------------------------------------------------
module tb_ifid_skid_register;

    localparam logic [31:0] NOP = 32'h00000013;

    // ------------------------------------------------------------ clock/reset
    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_illegal;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifid_skid_register dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_illegal(id_illegal)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int n_checks;
    int n_pass;

    // ------------------------------------------------------------ scoreboard
    task automatic check(input string name, input logic ev, input logic [63:0] epc,
                         input logic [31:0] ei, input logic eill, input logic eifr);
        n_checks++;
        if ({id_valid, id_pc, id_instr, id_illegal, if_ready} === {ev, epc, ei, eill, eifr})
            n_pass++;
        else
            $display("FAIL %s: got v=%0b pc=%h instr=%h ill=%0b ifr=%0b, want v=%0b pc=%h instr=%h ill=%0b ifr=%0b",
                     name, id_valid, id_pc, id_instr, id_illegal, if_ready,
                     ev, epc, ei, eill, eifr);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    // ------------------------------------------------------------ driver
    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic apply(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic fl, input logic rdy);
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        flush    = fl;
        id_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        flush    = 1'b0;
        id_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        rdy;
        logic        e_v;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_ill;
        logic        e_ifr;
    } vec_t;

    function automatic vec_t mk(logic v, logic [63:0] pc, logic [31:0] ins, logic fl, logic rdy,
                                logic e_v, logic [63:0] e_pc, logic [31:0] e_ins,
                                logic e_ill, logic e_ifr);
        vec_t r;
        r.v = v; r.pc = pc; r.ins = ins; r.fl = fl; r.rdy = rdy;
        r.e_v = e_v; r.e_pc = e_pc; r.e_ins = e_ins; r.e_ill = e_ill; r.e_ifr = e_ifr;
        return r;
    endfunction

    vec_t vecs[19];

    // ------------------------------------------------------------ reference model
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic        m_ready;
    logic [63:0] m_last_pc;
    int          m_stall;
    int          m_flush;

    task automatic model_reset();
        m_q.delete();
        m_ready   = 1'b1;
        m_last_pc = '0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // One clock of the model: FIFO of depth two, ready while it has room.
    task automatic model_step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                              input logic fl, input logic rdy);
        ent_t e;
        logic acc;
        logic con;
        acc = v & m_ready;
        con = (m_q.size() > 0) & rdy;
        if ((m_q.size() > 0) && !rdy) m_stall++;
        if (fl) m_flush++;
        if (fl) begin
            m_q.delete();
        end else begin
            if (con) void'(m_q.pop_front());
            if (acc) begin
                e.pc  = pc;
                e.ins = ins;
                m_q.push_back(e);
            end
        end
        m_ready = (m_q.size() < 2);
        if (m_q.size() > 0) m_last_pc = m_q[0].pc;
    endtask

    task automatic model_check(input string name);
        if (m_q.size() > 0)
            check(name, 1'b1, m_q[0].pc, m_q[0].ins, (m_q[0].ins[1:0] != 2'b11), m_ready);
        else
            check(name, 1'b0, m_last_pc, NOP, 1'b0, m_ready);
    endtask

    // ------------------------------------------------------------ test
    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset", 1'b0, 64'h0, NOP, 1'b0, 1'b1);
        rst_n = 1'b1;

        //             v  pc      instr          fl rdy  e_v e_pc    e_instr        ill ifr
        vecs[0]  = mk(1, 64'h00, 32'h00500093, 0, 1,   1, 64'h00, 32'h00500093, 0, 1);
        vecs[1]  = mk(1, 64'h04, 32'h00400113, 0, 1,   1, 64'h04, 32'h00400113, 0, 1);
        vecs[2]  = mk(1, 64'h08, 32'h00800193, 0, 1,   1, 64'h08, 32'h00800193, 0, 1);
        vecs[3]  = mk(1, 64'h0C, 32'h00C00213, 0, 1,   1, 64'h0C, 32'h00C00213, 0, 1);
        vecs[4]  = mk(0, 64'h00, 32'h00000000, 0, 1,   0, 64'h0C, NOP,          0, 1);
        vecs[5]  = mk(1, 64'h10, 32'h01000293, 0, 0,   1, 64'h10, 32'h01000293, 0, 1);
        vecs[6]  = mk(1, 64'h14, 32'h01400313, 0, 0,   1, 64'h10, 32'h01000293, 0, 0);
        vecs[7]  = mk(1, 64'h18, 32'h01800393, 0, 0,   1, 64'h10, 32'h01000293, 0, 0);
        vecs[8]  = mk(0, 64'h00, 32'h00000000, 0, 1,   1, 64'h14, 32'h01400313, 0, 1);
        vecs[9]  = mk(0, 64'h00, 32'h00000000, 0, 1,   0, 64'h14, NOP,          0, 1);
        vecs[10] = mk(1, 64'h20, 32'h02000413, 0, 0,   1, 64'h20, 32'h02000413, 0, 1);
        vecs[11] = mk(1, 64'h24, 32'h02400493, 0, 0,   1, 64'h20, 32'h02000413, 0, 0);
        vecs[12] = mk(1, 64'h28, 32'h02800513, 1, 0,   0, 64'h20, NOP,          0, 1);
        vecs[13] = mk(1, 64'h2C, 32'h02C00593, 1, 1,   0, 64'h20, NOP,          0, 1);
        vecs[14] = mk(0, 64'h00, 32'h00000000, 0, 1,   0, 64'h20, NOP,          0, 1);
        vecs[15] = mk(1, 64'h30, 32'h00004501, 0, 1,   1, 64'h30, 32'h00004501, 1, 1);
        vecs[16] = mk(1, 64'h34, 32'h00000513, 0, 0,   1, 64'h30, 32'h00004501, 1, 0);
        vecs[17] = mk(0, 64'h00, 32'h00000000, 0, 1,   1, 64'h34, 32'h00000513, 0, 1);
        vecs[18] = mk(0, 64'h00, 32'h00000000, 0, 1,   0, 64'h34, NOP,          0, 1);

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_pc, vecs[i].e_ins,
                  vecs[i].e_ill, vecs[i].e_ifr);
        end

        // Asynchronous reset with both slots full.
        apply(1, 64'h40, 32'h04000613, 0, 0);
        apply(1, 64'h44, 32'h04400693, 0, 0);
        check("midstall_full", 1'b1, 64'h40, 32'h04000613, 1'b0, 1'b0);
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_midstall", 1'b0, 64'h0, NOP, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 64'h0, 32'h0, 0, 1);
        check("rst_no_skid_left", 1'b0, 64'h0, NOP, 1'b0, 1'b1);

        // Random traffic against the queue model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        v;
            logic [63:0] pc;
            logic [31:0] ins;
            logic        fl;
            logic        rdy;
            v   = ($urandom_range(0, 3) != 0);
            pc  = {$urandom, $urandom};
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[1:0] = 2'b11;
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            model_step(v, pc, ins, fl, rdy);
            apply(v, pc, ins, fl, rdy);
            model_check("random");
        end
`ifdef IFID_PERF_CNT_EN
        check_val("rand_stall_cnt", stall_cnt, m_stall);
        check_val("rand_flush_cnt", flush_cnt, m_flush);
`endif

        // Three stall cycles then two flush pulses.
        do_reset();
        apply(1, 64'h50, 32'h05000713, 0, 0);
        apply(0, 64'h0, 32'h0, 0, 0);
        apply(0, 64'h0, 32'h0, 0, 0);
        apply(0, 64'h0, 32'h0, 0, 0);
        check("perf_stalled", 1'b1, 64'h50, 32'h05000713, 1'b0, 1'b1);
        apply(0, 64'h0, 32'h0, 1, 1);
        apply(0, 64'h0, 32'h0, 1, 1);
        check("perf_flushed", 1'b0, 64'h50, NOP, 1'b0, 1'b1);
`ifdef IFID_PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, 32'd3);
        check_val("flush_cnt", flush_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
